// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: synchronizes one selected ro_in bit and counts
// its rising edges over a selectable gate window, then holds the count for readout.
module ro_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ro_in,
  input  logic [3:0]       sel,
  input  logic [1:0]       win,
  input  logic             start,
  input  logic             byte_sel,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [CNT_W-1:0] result,
  output logic [7:0]       data_out
);

  generate
    if (CNT_W < 8 || CNT_W > 16) begin : g_bad_cnt_w
      $error("ro_freq_meter: CNT_W must be in 8..16");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("ro_freq_meter: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    HOLD
  } state_t;

  localparam int                TMR_W       = 14;
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SYNC_STAGES + 1);

  state_t                 state;
  logic [3:0]             sel_q;
  logic [1:0]             win_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [TMR_W-1:0]       timer;
  logic [CNT_W-1:0]       cnt;

  logic [TMR_W-1:0]       gate_last;
  logic                   rise;
  logic                   at_max;
  logic [CNT_W-1:0]       cnt_next;
  logic [15:0]            result_ext;

  // NOTE: every variable assigned in always_comb gets a default first so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    gate_last = 14'd255;
    case (win_q)
      2'd0:    gate_last = 14'd255;
      2'd1:    gate_last = 14'd1023;
      2'd2:    gate_last = 14'd4095;
      default: gate_last = 14'd16383;
    endcase
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign at_max   = (cnt == CNT_MAX);
  // Includes an edge seen in the current cycle so the final gate cycle counts.
  assign cnt_next = (rise && !at_max) ? cnt + CNT_W'(1) : cnt;

  assign result_ext = 16'(result);
  assign data_out   = byte_sel ? result_ext[15:8] : result_ext[7:0];

  // NOTE: all state here updates with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel_q  <= '0;
      win_q  <= '0;
      sync_q <= '0;
      hist_q <= 1'b0;
      timer  <= '0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in[sel_q]};
      hist_q <= sync_q[SYNC_STAGES-1];

      case (state)
        IDLE, HOLD: begin
          if (start) begin
            state <= SETTLE;
            sel_q <= sel;
            win_q <= win;
            cnt   <= '0;
            ovf   <= 1'b0;
            timer <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end

        // Lets the synchronizer and history flush the old channel before counting.
        SETTLE: begin
          if (timer == SETTLE_LAST) begin
            state <= GATE;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        GATE: begin
          if (rise && at_max) begin
            ovf <= 1'b1;
          end
          cnt <= cnt_next;
          if (timer == gate_last) begin
            result <= cnt_next;
            state  <= HOLD;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
